// File: rtl/keccak_state_ring.sv
// Ring of NBUF 25-lane Keccak state buffers: stream fill -> engine random access -> stream drain.
// Optional macro KECCAK_RING_BYPASS_EN: same-cycle same-lane engine read returns the write data.
module keccak_state_ring #(
    parameter int W    = 64,
    parameter int NBUF = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_push,
    input  logic         in_first,
    input  logic [W-1:0] in_data,
    output logic         in_stop,
    output logic         cp_valid,
    input  logic         cp_start,
    input  logic         cp_done,
    input  logic [2:0]   cp_rx,
    input  logic [2:0]   cp_ry,
    output logic [W-1:0] cp_rd,
    input  logic [2:0]   cp_wx,
    input  logic [2:0]   cp_wy,
    input  logic         cp_wr,
    input  logic [W-1:0] cp_wd,
    output logic         out_push,
    output logic         out_first,
    output logic [W-1:0] out_data,
    input  logic         out_stop
);

    localparam int BW    = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int DEPTH = NBUF * 25;
    localparam int AW    = $clog2(DEPTH);
`ifdef KECCAK_RING_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL,
        ST_COMPUTING,
        ST_DONE,
        ST_DRAINING
    } buf_state_e;

    buf_state_e     st_q [NBUF];
    buf_state_e     st_d [NBUF];
    logic [BW-1:0]  fill_ptr_q, comp_ptr_q, drain_ptr_q;
    logic [4:0]     fill_cnt_q, drain_cnt_q;
    logic [W-1:0]   mem_q [DEPTH];
    logic [W-1:0]   cp_rd_q, out_data_q;
    logic           out_push_q, out_first_q;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(NBUF - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AW-1:0] lane_addr(input logic [BW-1:0] b, input logic [4:0] lane);
        return AW'(b) * AW'(25) + AW'(lane);
    endfunction

    // Coordinates 5..7 fall outside the 5x5 state and are treated as holes.
    logic       rd_ok, wr_ok;
    logic [4:0] rd_lane, wr_lane;
    assign rd_ok   = (cp_rx < 3'd5) && (cp_ry < 3'd5);
    assign wr_ok   = (cp_wx < 3'd5) && (cp_wy < 3'd5);
    assign rd_lane = {2'b00, cp_rx} + 5'(cp_ry) * 5'd5;
    assign wr_lane = {2'b00, cp_wx} + 5'(cp_wy) * 5'd5;

    logic       fill_open, fill_acc, fill_last;
    logic [4:0] fill_idx;
    logic       computing, cp_wr_en, comp_done_ev, comp_start_ev;
    logic       drain_load, drain_xfer, drain_last;

    assign fill_open     = (st_q[fill_ptr_q] == ST_EMPTY) || (st_q[fill_ptr_q] == ST_FILLING);
    assign fill_acc      = in_push && fill_open;
    assign fill_idx      = in_first ? 5'd0 : fill_cnt_q;
    assign fill_last     = (fill_idx == 5'd24);

    assign computing     = (st_q[comp_ptr_q] == ST_COMPUTING);
    assign cp_wr_en      = computing && cp_wr && wr_ok;
    assign comp_done_ev  = cp_done && computing;
    assign comp_start_ev = cp_start && !cp_done && cp_valid;

    assign drain_load    = (st_q[drain_ptr_q] == ST_DONE);
    assign drain_xfer    = out_push_q && !out_stop;
    assign drain_last    = drain_xfer && (drain_cnt_q == 5'd24);

    assign in_stop   = !fill_open;
    assign cp_valid  = (st_q[comp_ptr_q] == ST_FULL);
    assign cp_rd     = cp_rd_q;
    assign out_push  = out_push_q;
    assign out_first = out_first_q;
    assign out_data  = out_data_q;

    // Each phase only touches buffers in its own states, so these updates never collide.
    always_comb begin
        st_d = st_q;
        if (fill_acc) begin
            st_d[fill_ptr_q] = fill_last ? ST_FULL : ST_FILLING;
        end
        if (comp_done_ev) begin
            st_d[comp_ptr_q] = ST_DONE;
        end else if (comp_start_ev) begin
            st_d[comp_ptr_q] = ST_COMPUTING;
        end
        if (drain_load) begin
            st_d[drain_ptr_q] = ST_DRAINING;
        end else if (drain_last) begin
            st_d[drain_ptr_q] = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_acc) begin
            mem_q[lane_addr(fill_ptr_q, fill_idx)] <= in_data;
        end
        if (cp_wr_en) begin
            mem_q[lane_addr(comp_ptr_q, wr_lane)] <= cp_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBUF; i++) begin
                st_q[i] <= ST_EMPTY;
            end
            fill_ptr_q  <= '0;
            comp_ptr_q  <= '0;
            drain_ptr_q <= '0;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            cp_rd_q     <= '0;
            out_data_q  <= '0;
            out_push_q  <= 1'b0;
            out_first_q <= 1'b0;
        end else begin
            st_q <= st_d;

            if (computing && rd_ok) begin
                if (BYPASS && cp_wr_en && (wr_lane == rd_lane)) begin
                    cp_rd_q <= cp_wd;
                end else begin
                    cp_rd_q <= mem_q[lane_addr(comp_ptr_q, rd_lane)];
                end
            end else begin
                cp_rd_q <= '0;
            end

            if (fill_acc) begin
                if (fill_last) begin
                    fill_ptr_q <= ptr_inc(fill_ptr_q);
                    fill_cnt_q <= '0;
                end else begin
                    fill_cnt_q <= fill_idx + 5'd1;
                end
            end

            if (comp_done_ev) begin
                comp_ptr_q <= ptr_inc(comp_ptr_q);
            end

            // Output registers hold while out_stop is asserted.
            if (drain_load) begin
                drain_cnt_q <= '0;
                out_push_q  <= 1'b1;
                out_first_q <= 1'b1;
                out_data_q  <= mem_q[lane_addr(drain_ptr_q, 5'd0)];
            end else if (drain_last) begin
                drain_ptr_q <= ptr_inc(drain_ptr_q);
                out_push_q  <= 1'b0;
                out_first_q <= 1'b0;
            end else if (drain_xfer) begin
                drain_cnt_q <= drain_cnt_q + 5'd1;
                out_first_q <= 1'b0;
                out_data_q  <= mem_q[lane_addr(drain_ptr_q, drain_cnt_q + 5'd1)];
            end
        end
    end

endmodule

// File: tb/tb_keccak_state_ring.sv
// Scoreboard bench for keccak_state_ring: stimulus queues expected drain lanes and read data,
// a negedge monitor pops and compares whenever the DUT presents a transfer or read result.
module tb_keccak_state_ring;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_push = 1'b0, in_first = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_stop, cp_valid;
    logic         cp_start = 1'b0, cp_done = 1'b0;
    logic [2:0]   cp_rx = '0, cp_ry = '0, cp_wx = '0, cp_wy = '0;
    logic [W-1:0] cp_rd;
    logic         cp_wr = 1'b0;
    logic [W-1:0] cp_wd = '0;
    logic         out_push, out_first;
    logic [W-1:0] out_data;
    logic         out_stop = 1'b0;

    keccak_state_ring #(.W(W), .NBUF(2)) dut (
        .clk(clk), .reset(reset),
        .in_push(in_push), .in_first(in_first), .in_data(in_data), .in_stop(in_stop),
        .cp_valid(cp_valid), .cp_start(cp_start), .cp_done(cp_done),
        .cp_rx(cp_rx), .cp_ry(cp_ry), .cp_rd(cp_rd),
        .cp_wx(cp_wx), .cp_wy(cp_wy), .cp_wr(cp_wr), .cp_wd(cp_wd),
        .out_push(out_push), .out_first(out_first), .out_data(out_data), .out_stop(out_stop)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W:0]   out_q [$];
    logic [W-1:0] rd_q [$];
    logic [W-1:0] lane_data [25];
    logic         rd_chk = 1'b0, rd_chk_d = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    always @(posedge clk) rd_chk_d <= rd_chk;

    always @(negedge clk) begin
        logic [W:0]   e;
        logic [W-1:0] r;
        if (!reset && out_push && !out_stop) begin
            if (out_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got lane %0h expected no transfer", out_data);
            end else begin
                e = out_q.pop_front();
                check("out_data", out_data, e[W-1:0]);
                check("out_first", W'(out_first), W'(e[W]));
            end
        end
        if (rd_chk_d) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected nothing queued", cp_rd);
            end else begin
                r = rd_q.pop_front();
                check("cp_rd", cp_rd, r);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [W-1:0] base);
        for (int i = 0; i < 25; i++) lane_data[i] = base + W'(i);
    endtask

    // Streams lane_data; optionally checks cp_valid rises exactly on lane 24.
    task automatic fill_state(input bit first0, input bit chk_valid, output bit stop_seen);
        stop_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            in_push  = 1'b1;
            in_first = first0 && (i == 0);
            in_data  = lane_data[i];
            stop_seen |= in_stop;
            if (chk_valid && i == 24) check("cp_valid_before_last", W'(cp_valid), 0);
            tick();
        end
        in_push  = 1'b0;
        in_first = 1'b0;
        if (chk_valid) check("cp_valid_after_last", W'(cp_valid), 1);
    endtask

    task automatic expect_drain();
        for (int i = 0; i < 25; i++) out_q.push_back({(i == 0), lane_data[i]});
    endtask

    task automatic start_pulse();
        cp_start = 1'b1;
        tick();
        cp_start = 1'b0;
    endtask

    task automatic done_pulse();
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
    endtask

    task automatic rd(input logic [2:0] x, input logic [2:0] y, input logic [W-1:0] exp);
        cp_rx = x;
        cp_ry = y;
        rd_chk = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_chk = 1'b0;
    endtask

    task automatic wr(input logic [2:0] x, input logic [2:0] y, input logic [W-1:0] d);
        cp_wx = x;
        cp_wy = y;
        cp_wd = d;
        cp_wr = 1'b1;
        tick();
        cp_wr = 1'b0;
    endtask

    // Waits for the scoreboard to empty; optionally stalls 5 cycles when lane stall_val is shown.
    task automatic wait_drain(input bit do_stall, input logic [W-1:0] stall_val);
        bit stalled = 1'b0;
        for (int n = 0; n < 200 && out_q.size() != 0; n++) begin
            tick();
            if (do_stall && !stalled && out_push && out_data == stall_val) begin
                stalled  = 1'b1;
                out_stop = 1'b1;
                repeat (5) begin
                    tick();
                    check("stall_out_data", out_data, stall_val);
                    check("stall_out_push", W'(out_push), 1);
                end
                out_stop = 1'b0;
            end
        end
        check("drain_complete", W'(out_q.size()), 0);
        check("out_push_idle", W'(out_push), 0);
    endtask

    initial begin
        bit stop_seen;
        logic [W-1:0] same_exp;

        // Reset state
        repeat (2) tick();
        check("rst_in_stop", W'(in_stop), 0);
        check("rst_cp_valid", W'(cp_valid), 0);
        check("rst_cp_rd", cp_rd, 0);
        check("rst_out_push", W'(out_push), 0);
        check("rst_out_first", W'(out_first), 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        // Stream lanes 0..24 with data = index
        set_data(0);
        fill_state(1'b1, 1'b1, stop_seen);
        check("in_stop_during_fill", W'(stop_seen | in_stop), 0);

        // Claim, read (3,4), write (0,0), drain with a stall at lane 12
        start_pulse();
        check("cp_valid_after_start", W'(cp_valid), 0);
        rd(3'd3, 3'd4, 23);
        wr(3'd0, 3'd0, 64'hAAAA);
        rd(3'd0, 3'd0, 64'hAAAA);
        lane_data[0] = 64'hAAAA;
        expect_drain();
        done_pulse();
        check("out_push_after_done", W'(out_push), 0);
        tick();
        check("drain_start_push", W'(out_push), 1);
        check("drain_start_first", W'(out_first), 1);
        wait_drain(1'b1, 12);

        // Same-cycle read/write of lane (2,2) and out-of-range coordinates
        set_data(0);
        lane_data[12] = 7;
        fill_state(1'b1, 1'b1, stop_seen);
        start_pulse();
`ifdef KECCAK_RING_BYPASS_EN
        same_exp = 9;
`else
        same_exp = 7;
`endif
        cp_rx = 3'd2; cp_ry = 3'd2;
        cp_wx = 3'd2; cp_wy = 3'd2; cp_wd = 9; cp_wr = 1'b1;
        rd_chk = 1'b1;
        rd_q.push_back(same_exp);
        tick();
        rd_chk = 1'b0;
        cp_wr = 1'b0;
        rd(3'd2, 3'd2, 9);
        rd(3'd5, 3'd0, 0);
        wr(3'd0, 3'd5, 64'hDEAD);
        rd(3'd0, 3'd0, 0);
        lane_data[12] = 9;
        expect_drain();
        done_pulse();
        wait_drain(1'b0, 0);
        rd(3'd1, 3'd1, 0);

        // Two states loaded, third state back-pressured until a drain completes
        set_data(200);
        fill_state(1'b1, 1'b1, stop_seen);
        set_data(300);
        fill_state(1'b1, 1'b0, stop_seen);
        in_push = 1'b1; in_first = 1'b1; in_data = 64'h999;
        check("in_stop_third_state", W'(in_stop), 1);
        repeat (3) tick();
        in_push = 1'b0; in_first = 1'b0;
        set_data(200);
        expect_drain();
        start_pulse();
        done_pulse();
        wait_drain(1'b0, 0);
        check("in_stop_after_drain", W'(in_stop), 0);
        set_data(400);
        fill_state(1'b1, 1'b0, stop_seen);
        set_data(300);
        expect_drain();
        start_pulse();
        done_pulse();
        wait_drain(1'b0, 0);
        set_data(400);
        expect_drain();
        start_pulse();
        done_pulse();
        wait_drain(1'b0, 0);

        // Reset mid-stream, then a fill without in_first starts at lane 0
        for (int i = 0; i < 10; i++) begin
            in_push = 1'b1; in_first = (i == 0); in_data = 64'h700 + W'(i);
            tick();
        end
        in_push = 1'b0; in_first = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_cp_valid", W'(cp_valid), 0);
        check("midrst_in_stop", W'(in_stop), 0);
        set_data(64'h800);
        fill_state(1'b0, 1'b1, stop_seen);
        expect_drain();
        start_pulse();
        done_pulse();
        wait_drain(1'b0, 0);

        // Restart: 10 lanes, then in_first with 0x55 and a full 25-lane state
        for (int i = 0; i < 10; i++) begin
            in_push = 1'b1; in_first = (i == 0); in_data = 64'h500 + W'(i);
            tick();
        end
        in_push = 1'b0; in_first = 1'b0;
        check("restart_partial_valid", W'(cp_valid), 0);
        set_data(64'h600);
        lane_data[0] = 64'h55;
        fill_state(1'b1, 1'b1, stop_seen);
        expect_drain();
        start_pulse();
        done_pulse();
        wait_drain(1'b0, 0);
        check("rd_queue_empty", W'(rd_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
